// File: rtl/scan_mux.sv
// Channel scan multiplexer: manual select or auto-scan with a prescaled pointer.
// The outputs o, sel, an and tick are all registered and update on the same edge.
module scan_mux #(
    parameter  int W   = 4,
    parameter  int N   = 4,
    parameter  int DIV = 16,
    localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  I,
    input  logic [SW-1:0]   s,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    o,
    output logic [SW-1:0]   sel,
    output logic [N-1:0]    an,
    output logic            tick
);

    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [SW-1:0]   LAST_CH  = SW'(N - 1);
    localparam logic [PW-1:0]   LAST_CNT = PW'(DIV - 1);

    logic [SW-1:0] r_ptr;
    logic [PW-1:0] r_pcnt;
    logic [W-1:0]  r_o;
    logic [N-1:0]  r_an;
    logic          r_tick;

    logic [SW-1:0] w_s_lim;
    logic [SW-1:0] w_ptr_nxt;
    logic [PW-1:0] w_pcnt_nxt;
    logic          w_tick_nxt;
    logic          w_wrap;
    logic [W-1:0]  w_o_nxt;
    logic [N-1:0]  w_an_nxt;

    // Out-of-range manual selects fall back to channel 0; a full power-of-two N has none.
    generate
        if ((1 << SW) == N) begin : g_s_full
            assign w_s_lim = s;
        end else begin : g_s_clip
            assign w_s_lim = (s < SW'(N)) ? s : '0;
        end
    endgenerate

    assign w_wrap = (r_pcnt == LAST_CNT);

    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_pcnt_nxt = r_pcnt;
        w_tick_nxt = 1'b0;
        if (mode) begin
            if (w_wrap) begin
                w_pcnt_nxt = '0;
                w_ptr_nxt  = (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
                w_tick_nxt = 1'b1;
            end else begin
                w_pcnt_nxt = r_pcnt + 1'b1;
            end
        end else begin
            w_ptr_nxt  = w_s_lim;
            w_pcnt_nxt = '0;
        end
    end

    // Data and strobe are taken from the next pointer so o, sel and an never disagree.
    assign w_o_nxt  = I[w_ptr_nxt*W +: W];
    assign w_an_nxt = N'(1) << w_ptr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_pcnt <= '0;
            r_o    <= '0;
            r_an   <= N'(1);
            r_tick <= 1'b0;
        end else if (en) begin
            r_ptr  <= w_ptr_nxt;
            r_pcnt <= w_pcnt_nxt;
            r_o    <= w_o_nxt;
            r_an   <= w_an_nxt;
            r_tick <= w_tick_nxt;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o    = r_o;
    assign sel  = r_ptr;
    assign an   = r_an;
    assign tick = r_tick;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: N=4 and N=3 instances (W=4, DIV=3) driven in lockstep,
// checked against a behavioural model of pointer, prescaler and output data.
module tb_scan_mux;

    localparam int W   = 4;
    localparam int DIV = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i4;
    logic [11:0] i3;
    logic [1:0]  s;
    logic        mode;
    logic        en;

    logic [3:0]  o4, o3;
    logic [1:0]  sel4, sel3;
    logic [3:0]  an4;
    logic [2:0]  an3;
    logic        tick4, tick3;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = N=4 instance, index 1 = N=3 instance
    int m_ptr[2];
    int m_pcnt[2];
    int m_o[2];
    int m_tick[2];

    always #5 clk = ~clk;

    scan_mux #(.W(W), .N(4), .DIV(DIV)) dut4 (
        .clk(clk), .rst(rst), .I(i4), .s(s), .mode(mode), .en(en),
        .o(o4), .sel(sel4), .an(an4), .tick(tick4)
    );

    scan_mux #(.W(W), .N(3), .DIV(DIV)) dut3 (
        .clk(clk), .rst(rst), .I(i3), .s(s), .mode(mode), .en(en),
        .o(o3), .sel(sel3), .an(an3), .tick(tick3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_pcnt[k] = 0; m_o[k] = 0; m_tick[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input int n, input longint data);
        if (!en) begin
            m_tick[k] = 0;
        end else begin
            if (!mode) begin
                m_ptr[k]  = (int'(s) < n) ? int'(s) : 0;
                m_pcnt[k] = 0;
                m_tick[k] = 0;
            end else if (m_pcnt[k] == DIV - 1) begin
                m_pcnt[k] = 0;
                m_ptr[k]  = (m_ptr[k] + 1) % n;
                m_tick[k] = 1;
            end else begin
                m_pcnt[k] = m_pcnt[k] + 1;
                m_tick[k] = 0;
            end
            m_o[k] = int'((data >> (m_ptr[k] * W)) & 15);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, "/o4"},    32'(o4),    32'(m_o[0]));
        chk({ph, "/sel4"},  32'(sel4),  32'(m_ptr[0]));
        chk({ph, "/an4"},   32'(an4),   32'(1 << m_ptr[0]));
        chk({ph, "/tick4"}, 32'(tick4), 32'(m_tick[0]));
        chk({ph, "/o3"},    32'(o3),    32'(m_o[1]));
        chk({ph, "/sel3"},  32'(sel3),  32'(m_ptr[1]));
        chk({ph, "/an3"},   32'(an3),   32'(1 << m_ptr[1]));
        chk({ph, "/tick3"}, 32'(tick3), 32'(m_tick[1]));
    endtask

    // One clock edge: inputs already driven, update model, sample 1 time unit later.
    task automatic step(input string ph);
        @(posedge clk);
        model_edge(0, 4, longint'(i4));
        model_edge(1, 3, longint'(i3));
        #1;
        check_all(ph);
    endtask

    task automatic pulse_reset(input string ph);
        #1 rst = 1'b1;
        model_reset();
        #1 check_all({ph, "_rst_asserted"});
        #1 rst = 1'b0;
    endtask

    initial begin
        i4   = 16'h8421;
        i3   = 12'h421;
        s    = 2'd0;
        mode = 1'b0;
        en   = 1'b0;

        // reset pulse between edges, outputs must clear immediately
        #7 rst = 1'b1;
        model_reset();
        #1 check_all("reset");
        #1 rst = 1'b0;
        en = 1'b1;
        step("first_edge");
        chk("first_edge_o4_lit", 32'(o4), 32'h1);

        // manual sweep
        for (int v = 0; v < 4; v++) begin
            s = 2'(v);
            step("manual");
            chk("manual_o4_lit", 32'(o4), 32'(1 << v));
            step("manual_hold");
        end
        chk("manual_s3_n3_sel", 32'(sel3), 32'h0);

        // data tracking on channel 2
        s = 2'd2;
        step("track_pre");
        i4 = 16'h8F21;
        i3 = 12'hF21;
        step("track");
        chk("track_o4_lit", 32'(o4), 32'hF);

        // auto scan from ptr=0
        i4 = 16'h8421;
        i3 = 12'h421;
        s  = 2'd0;
        step("auto_pre");
        mode = 1'b1;
        for (int c = 0; c < 13; c++) begin
            step("auto");
            chk("auto_onehot4", 32'($onehot(an4)), 32'h1);
        end

        // freeze mid-period
        step("freeze_pre");
        en = 1'b0;
        for (int c = 0; c < 5; c++) step("freeze");
        en = 1'b1;
        for (int c = 0; c < 6; c++) step("resume");

        // reset mid-scan, then continue in auto
        pulse_reset("midscan");
        step("post_rst_auto");
        chk("post_rst_o4_lit", 32'(o4), 32'h1);

        // back to manual with out-of-range select for N=3
        mode = 1'b0;
        s    = 2'd3;
        step("manual_s3");
        chk("manual_s3_sel3_lit", 32'(sel3), 32'h0);
        chk("manual_s3_sel4_lit", 32'(sel4), 32'h3);

        // randomized phase
        for (int c = 0; c < 400; c++) begin
            i4 = 16'($urandom);
            i3 = 12'($urandom);
            if ($urandom_range(0, 9) == 0) s = 2'($urandom);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            en = ($urandom_range(0, 7) != 0);
            if (c == 200) pulse_reset("rand");
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
